uart_ctrl: RTL and testbench
============================

Name: uart_ctrl

Overview:
- Parametrised full-duplex UART controller. Adds configurable data width, parity, stop bits and 16x-oversampled RX with a receive FIFO, per-byte error flags and CTS/RTS flow control.
- Sits between the MCU peripheral bus register block and the rx/tx pins.
- TX and RX paths are independent and may run simultaneously.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
RX_FIFO_DEPTH, 4, RX FIFO entries, power of two, minimum 2
DIV_WIDTH, 12, width of baud divisor input

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
baud_div  in  DIV_WIDTH  oversample tick period is baud_div+1 clk; bit time is 16*(baud_div+1) clk
parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
two_stop  in  1  1 = TX sends 2 stop bits; RX always checks the first stop bit only
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  request to send tx_data
tx_ready  out  1  TX idle and cts_n low; handshake completes when tx_valid & tx_ready
tx_busy  out  1  frame in progress
tx  out  1  serial out, idle high
rx  in  1  serial in (asynchronous)
rx_data  out  DATA_BITS  FIFO head data
rx_frame_err  out  1  FIFO head stop bit was low
rx_parity_err  out  1  FIFO head parity mismatch
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop FIFO head when rx_valid & rx_ready
rx_overrun  out  1  sticky: frame dropped because FIFO was full
rx_overrun_clr  in  1  clears rx_overrun
cts_n  in  1  active-low clear-to-send from peer
rts_n  out  1  active-low request-to-send to peer

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_ready=0 during reset, rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0, rts_n=1. The FIFO is emptied and all counters are zeroed.
- Reset asserted mid-frame aborts the frame immediately; tx returns high the next cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on handshake; tx_data is latched. tx goes low the cycle after the handshake.
  - Each state lasts exactly 16*(baud_div+1) clk. The TX divider restarts at the handshake.
  - Data is sent LSB first.
  - PARITY is skipped when parity_mode is 00 or 11.
  - STOP2 runs only if two_stop=1.
  - After the last stop bit, the FSM returns to IDLE. tx_ready can reassert the following cycle.
- cts_n is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- parity_mode, two_stop and baud_div are latched at the handshake (TX) or at start detect (RX). Changes mid-frame have no effect.
- RX input: 2-flop synchroniser. RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on synced rx starts the RX divider from zero.
  - START: sample at oversample tick 8. If rx is high, it is a false start; return to IDLE and push nothing.
  - Subsequent bits are sampled at 16-tick intervals from the start-bit midpoint.
  - STOP: sample the stop bit. Parity error = received parity ≠ computed parity. Frame error = stop sample is 0.
  - Then push {data, frame_err, parity_err} and return to IDLE, ready for the next falling edge.
- FIFO:
  - Push when not full: entry becomes visible on rx_valid the next cycle.
  - Push when full: entry dropped, rx_overrun set.
  - Push and pop in the same cycle: both succeed, including when full (count unchanged, no overrun) and when empty-then-push (push only, since rx_valid=0).
  - rx_overrun_clr and a new overrun in the same cycle: overrun wins.
- rts_n is registered. It is 1 when FIFO count >= RX_FIFO_DEPTH-1, otherwise 0.
- The RX path runs regardless of rts_n.

Test Plan:
- baud_div=0, parity none, two_stop=0, send 0xA5 -> tx low the cycle after the handshake; bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 clk; tx_ready reasserts 160 clk after tx went low.
- parity_mode=01, two_stop=1, send 0x07 -> parity bit 1; two 16-clk stop bits; frame is 192 clk total.
- Loop tx to rx, baud_div=3, parity odd, send 0x3C -> rx_valid rises with rx_data=0x3C and both error flags 0.
- Drive a frame with the stop bit low, then a frame with a flipped parity bit -> entries carry frame_err=1 and parity_err=1 respectively, and the data is still stored.
- RX_FIFO_DEPTH=4, receive 5 frames with no pop -> rts_n=1 after the 3rd; 5th dropped; rx_overrun=1 until rx_overrun_clr; the first 4 pop in order.
- cts_n=1 with tx_valid held -> no frame; cts_n falls -> frame starts. rx glitch low for 4 oversample ticks -> false start, nothing pushed.

Source files
------------

// File: rtl/uart_ctrl.sv
// Full-duplex UART controller: configurable frame format, 16x-oversampled receiver
// with a small receive FIFO carrying per-entry error flags, and CTS/RTS flow control.
module uart_ctrl #(
    parameter int DATA_BITS     = 8,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int DIV_WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clr,
    input  logic                 cts_n,
    output logic                 rts_n
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(RX_FIFO_DEPTH);
    localparam logic [AW:0] RTS_CNT = (AW + 1)'(RX_FIFO_DEPTH - 1);

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    tx_state_t            tx_state_reg, tx_state_next;
    logic [DIV_WIDTH-1:0] tx_div_reg, tx_div_next;
    logic [DIV_WIDTH-1:0] tx_bd_reg, tx_bd_next;
    logic [3:0]           tx_tick_reg, tx_tick_next;
    logic [BW-1:0]        tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next;
    logic                 tx_par_en_reg, tx_par_en_next;
    logic                 tx_two_reg, tx_two_next;
    logic                 tx_reg, tx_next;
    logic                 tx_hs, tx_bit_end;

    assign tx_ready   = rst_n && (tx_state_reg == TX_IDLE) && !cts_n;
    assign tx_hs      = tx_valid && tx_ready;
    assign tx_busy    = (tx_state_reg != TX_IDLE);
    assign tx         = tx_reg;
    assign tx_bit_end = (tx_div_reg == tx_bd_reg) && (tx_tick_reg == 4'd15);

    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_div_next    = tx_div_reg;
        tx_bd_next     = tx_bd_reg;
        tx_tick_next   = tx_tick_reg;
        tx_bit_next    = tx_bit_reg;
        tx_shift_next  = tx_shift_reg;
        tx_par_next    = tx_par_reg;
        tx_par_en_next = tx_par_en_reg;
        tx_two_next    = tx_two_reg;
        tx_next        = 1'b1;

        if (tx_state_reg != TX_IDLE) begin
            if (tx_div_reg == tx_bd_reg) begin
                tx_div_next  = '0;
                tx_tick_next = tx_tick_reg + 4'd1;
            end else begin
                tx_div_next = tx_div_reg + 1'b1;
            end
        end

        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_hs) begin
                    tx_state_next  = TX_START;
                    tx_div_next    = '0;
                    tx_tick_next   = '0;
                    tx_bd_next     = baud_div;
                    tx_shift_next  = tx_data;
                    tx_par_en_next = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    // Even parity bit is the XOR of the data; odd inverts it.
                    tx_par_next    = (^tx_data) ^ (parity_mode == 2'b10);
                    tx_two_next    = two_stop;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == LAST_BIT) begin
                        tx_state_next = tx_par_en_reg ? TX_PARITY : TX_STOP1;
                    end else begin
                        tx_bit_next = tx_bit_reg + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_next = TX_STOP1;
            end
            TX_STOP1: begin
                if (tx_bit_end) tx_state_next = tx_two_reg ? TX_STOP2 : TX_IDLE;
            end
            TX_STOP2: begin
                if (tx_bit_end) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase

        // Line level is registered from the upcoming state so tx never glitches.
        case (tx_state_next)
            TX_START:  tx_next = 1'b0;
            TX_DATA:   tx_next = tx_shift_next[0];
            TX_PARITY: tx_next = tx_par_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg  <= TX_IDLE;
            tx_div_reg    <= '0;
            tx_bd_reg     <= '0;
            tx_tick_reg   <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            tx_par_reg    <= 1'b0;
            tx_par_en_reg <= 1'b0;
            tx_two_reg    <= 1'b0;
            tx_reg        <= 1'b1;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_div_reg    <= tx_div_next;
            tx_bd_reg     <= tx_bd_next;
            tx_tick_reg   <= tx_tick_next;
            tx_bit_reg    <= tx_bit_next;
            tx_shift_reg  <= tx_shift_next;
            tx_par_reg    <= tx_par_next;
            tx_par_en_reg <= tx_par_en_next;
            tx_two_reg    <= tx_two_next;
            tx_reg        <= tx_next;
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t            rx_state_reg, rx_state_next;
    logic                 rx_s1_reg, rx_s2_reg, rx_prev_reg;
    logic [DIV_WIDTH-1:0] rx_div_reg, rx_div_next;
    logic [DIV_WIDTH-1:0] rx_bd_reg, rx_bd_next;
    logic [3:0]           rx_tick_reg, rx_tick_next;
    logic [BW-1:0]        rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_par_en_reg, rx_par_en_next;
    logic                 rx_odd_reg, rx_odd_next;
    logic                 rx_pbit_reg, rx_pbit_next;
    logic                 rx_sample, rx_push;
    logic [EW-1:0]        rx_entry;

    // Tick 8 of each bit is its midpoint; counting from the start edge, that is the end of tick 7.
    assign rx_sample = (rx_state_reg != RX_IDLE) && (rx_div_reg == rx_bd_reg) && (rx_tick_reg == 4'd7);
    assign rx_entry  = {rx_shift_reg, ~rx_s2_reg,
                        rx_par_en_reg && (rx_pbit_reg != ((^rx_shift_reg) ^ rx_odd_reg))};

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_div_next    = rx_div_reg;
        rx_bd_next     = rx_bd_reg;
        rx_tick_next   = rx_tick_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        rx_par_en_next = rx_par_en_reg;
        rx_odd_next    = rx_odd_reg;
        rx_pbit_next   = rx_pbit_reg;
        rx_push        = 1'b0;

        if (rx_state_reg != RX_IDLE) begin
            if (rx_div_reg == rx_bd_reg) begin
                rx_div_next  = '0;
                rx_tick_next = rx_tick_reg + 4'd1;
            end else begin
                rx_div_next = rx_div_reg + 1'b1;
            end
        end

        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_s2_reg) begin
                    rx_state_next  = RX_START;
                    rx_div_next    = '0;
                    rx_tick_next   = '0;
                    rx_bd_next     = baud_div;
                    rx_par_en_next = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    rx_odd_next    = (parity_mode == 2'b10);
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    if (rx_s2_reg) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_state_next = RX_DATA;
                        rx_bit_next   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_next = {rx_s2_reg, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == LAST_BIT) begin
                        rx_state_next = rx_par_en_reg ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_pbit_next  = rx_s2_reg;
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_push       = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg  <= RX_IDLE;
            rx_s1_reg     <= 1'b1;
            rx_s2_reg     <= 1'b1;
            rx_prev_reg   <= 1'b1;
            rx_div_reg    <= '0;
            rx_bd_reg     <= '0;
            rx_tick_reg   <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_par_en_reg <= 1'b0;
            rx_odd_reg    <= 1'b0;
            rx_pbit_reg   <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_s1_reg     <= rx;
            rx_s2_reg     <= rx_s1_reg;
            rx_prev_reg   <= rx_s2_reg;
            rx_div_reg    <= rx_div_next;
            rx_bd_reg     <= rx_bd_next;
            rx_tick_reg   <= rx_tick_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_par_en_reg <= rx_par_en_next;
            rx_odd_reg    <= rx_odd_next;
            rx_pbit_reg   <= rx_pbit_next;
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [EW-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          overrun_reg, rts_n_reg;
    logic          fifo_full, fifo_pop, push_ok, overrun_set;
    logic [EW-1:0] head;

    assign fifo_full   = (count_reg == FIFO_FULL_CNT);
    assign rx_valid    = (count_reg != '0);
    assign fifo_pop    = rx_valid && rx_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok     = rx_push && (!fifo_full || fifo_pop);
    assign overrun_set = rx_push && fifo_full && !fifo_pop;
    assign head        = fifo_mem[rd_ptr_reg];

    assign rx_data       = rx_valid ? head[EW-1:2] : '0;
    assign rx_frame_err  = rx_valid && head[1];
    assign rx_parity_err = rx_valid && head[0];
    assign rx_overrun    = overrun_reg;
    assign rts_n         = rts_n_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !fifo_pop) count_next = count_reg + 1'b1;
        else if (!push_ok && fifo_pop) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= rx_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
            rts_n_reg   <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (overrun_set) overrun_reg <= 1'b1;
            else if (rx_overrun_clr) overrun_reg <= 1'b0;
            rts_n_reg <= (count_next >= RTS_CNT);
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed and randomized bench for uart_ctrl: TX bit timing, RX loopback and
// injected errors, FIFO overrun/flow control, CTS gating and false-start rejection.
module tb_uart_ctrl;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] baud_div = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx_busy, tx;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_frame_err, rx_parity_err, rx_valid;
    logic          rx_ready = 1'b0;
    logic          rx_overrun;
    logic          rx_overrun_clr = 1'b0;
    logic          cts_n = 1'b0;
    logic          rts_n;

    logic loopback = 1'b0;
    logic rx_drv = 1'b1;
    assign rx = loopback ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_ctrl #(.DATA_BITS(DB), .RX_FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
        .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx(tx), .rx(rx), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr), .cts_n(cts_n), .rts_n(rts_n)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ent_t;

    ent_t exp_q[$];
    bit   exp_ovr = 1'b0;
    bit   frame_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of line levels: start, data LSB first, optional parity, stop(s).
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] m, input bit two,
                                        input bit stopv, input bit flip);
        int ones;
        bit p;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < DB; i++) frame_q.push_back(d[i]);
        if (m == 2'd1 || m == 2'd2) begin
            ones = $countones(d);
            p = (m == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0);
            frame_q.push_back(p ^ flip);
        end
        frame_q.push_back(stopv);
        if (two) frame_q.push_back(1'b1);
    endfunction

    function automatic void model_push(input ent_t e);
        if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(e);
    endfunction

    task automatic send_tx(input logic [7:0] d, input logic [1:0] m, input bit two, input int bd,
                           input int exp_len);
        int k = 0;
        int bad = 0;
        int busy = 0;
        int len;
        logic last_ready = 1'b0;
        parity_mode = m;
        two_stop = two;
        baud_div = DW'(bd);
        build_frame(d, m, two, 1'b1, 1'b0);
        len = 16 * (bd + 1);
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            for (int j = 0; j < len; j++) begin
                // Mid-frame config changes must not disturb the frame in flight.
                if (i == 2 && j == 0) begin
                    baud_div = DW'(bd ^ 1);
                    two_stop = ~two;
                    parity_mode = ~m;
                end
                if (tx !== frame_q[i]) bad++;
                if (tx_busy) busy++;
                last_ready = tx_ready;
                @(negedge clk);
            end
        end
        $display("[TB] tx 0x%02h mode=%0d two=%0d bd=%0d busy=%0d bad_cycles=%0d", d, m, two, bd, busy, bad);
        check("tx_bits", 32'(bad), 32'd0);
        check("tx_frame_len", 32'(busy), 32'(exp_len));
        check("tx_ready_in_frame", 32'(last_ready), 32'd0);
        check("tx_ready_after", 32'(tx_ready), 32'd1);
        check("tx_busy_after", 32'(tx_busy), 32'd0);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic [1:0] m, input int bd,
                            input bit stopv, input bit flip);
        int len;
        ent_t e;
        parity_mode = m;
        baud_div = DW'(bd);
        build_frame(d, m, 1'b0, stopv, flip);
        len = 16 * (bd + 1);
        for (int i = 0; i < frame_q.size(); i++) begin
            rx_drv = frame_q[i];
            repeat (len) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * len) @(negedge clk);
        e.d = d;
        e.fe = ~stopv;
        e.pe = flip && (m == 2'd1 || m == 2'd2);
        model_push(e);
        $display("[TB] rx frame 0x%02h mode=%0d stop=%0d flip=%0d queued=%0d", d, m, stopv, flip, exp_q.size());
    endtask

    task automatic pop_check(input string tag);
        ent_t e;
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_model_empty"}, 32'd1, 32'(exp_q.size()));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(rx_data), 32'(e.d));
            check({tag, "_ferr"}, 32'(rx_frame_err), 32'(e.fe));
            check({tag, "_perr"}, 32'(rx_parity_err), 32'(e.pe));
            $display("[TB] pop %s data=0x%02h fe=%0d pe=%0d", tag, rx_data, rx_frame_err, rx_parity_err);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        bit         two;
        int         bd;
        int         k;
        int         quiet;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        check("rst_perr", 32'(rx_parity_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_rts_n", 32'(rts_n), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic TX frames
        send_tx(8'hA5, 2'b00, 1'b0, 0, 160);
        send_tx(8'h07, 2'b01, 1'b1, 0, 192);

        // Loopback, odd parity
        loopback = 1'b1;
        send_tx(8'h3C, 2'b10, 1'b0, 3, 11 * 64);
        model_push('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
        pop_check("loop_3c");
        loopback = 1'b0;

        // Injected stop-bit and parity errors
        drive_rx(8'h96, 2'b00, 1, 1'b0, 1'b0);
        drive_rx(8'h5B, 2'b01, 1, 1'b1, 1'b1);
        pop_check("frame_err");
        pop_check("parity_err");

        // Fill the FIFO, overflow, flow control
        for (int n = 0; n < 5; n++) begin
            drive_rx(8'($urandom_range(0, 255)), 2'b00, 0, 1'b1, 1'b0);
            check("rts_n_fill", 32'(rts_n), 32'(exp_q.size() >= DEPTH - 1));
        end
        check("overrun_set", 32'(rx_overrun), 32'(exp_ovr));
        repeat (5) @(negedge clk);
        check("overrun_sticky", 32'(rx_overrun), 32'd1);
        rx_overrun_clr = 1'b1;
        @(negedge clk);
        rx_overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        check("overrun_clr", 32'(rx_overrun), 32'(exp_ovr));
        for (int n = 0; n < DEPTH; n++) pop_check("fifo_order");
        check("fifo_drained", 32'(rx_valid), 32'd0);
        check("rts_n_drained", 32'(rts_n), 32'd0);

        // CTS gating
        cts_n = 1'b1;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        quiet = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) quiet++;
        end
        check("cts_blocked", 32'(quiet), 32'd0);
        check("cts_tx_ready", 32'(tx_ready), 32'd0);
        cts_n = 1'b0;
        @(negedge clk);
        tx_valid = 1'b0;
        check("cts_start_tx", 32'(tx), 32'd0);
        check("cts_start_busy", 32'(tx_busy), 32'd1);
        cts_n = 1'b1;
        repeat (32) @(negedge clk);
        check("cts_no_abort", 32'(tx_busy), 32'd1);
        k = 0;
        while (tx_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("cts_frame_done", 32'(tx_busy), 32'd0);
        cts_n = 1'b0;
        $display("[TB] cts frame finished after %0d more cycles", k);

        // False start: glitch of 4 oversample ticks
        baud_div = DW'(1);
        parity_mode = 2'b00;
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (96) @(negedge clk);
        check("glitch_no_push", 32'(rx_valid), 32'd0);
        drive_rx(8'hC3, 2'b00, 1, 1'b1, 1'b0);
        pop_check("after_glitch");

        // Randomized loopback frames
        loopback = 1'b1;
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            bd = int'($urandom_range(0, 3));
            build_frame(d, m, two, 1'b1, 1'b0);
            send_tx(d, m, two, bd, frame_q.size() * 16 * (bd + 1));
            model_push('{d: d, fe: 1'b0, pe: 1'b0});
            pop_check("rand_loop");
        end
        loopback = 1'b0;

        // Reset mid-frame
        send_tx_start: begin
            tx_data = 8'h00;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (40) @(negedge clk);
            check("midrst_pre_tx", 32'(tx), 32'd0);
            rst_n = 1'b0;
            @(negedge clk);
            check("midrst_tx", 32'(tx), 32'd1);
            check("midrst_busy", 32'(tx_busy), 32'd0);
            rst_n = 1'b1;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
